// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Frame layout: sync, opcode, addr_h, addr_l, data_h, data_l, checksum.
package uart_cmd_pkg;

    localparam int         FRAME_LEN         = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Opcodes understood by the ODIN SPI master; the parser forwards them unchecked.
    localparam logic [7:0] OP_WRITE_REG  = 8'h01;
    localparam logic [7:0] OP_READ_REG   = 8'h02;
    localparam logic [7:0] OP_WRITE_SRAM = 8'h03;
    localparam logic [7:0] OP_SPIKE      = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OP     = 3'd1,
        ST_ADDR_H = 3'd2,
        ST_ADDR_L = 3'd3,
        ST_DATA_H = 3'd4,
        ST_DATA_L = 3'd5,
        ST_CSUM   = 3'd6,
        ST_ISSUE  = 3'd7
    } state_e;

    function automatic logic [7:0] frame_csum(
        input logic [7:0] op,
        input logic [7:0] addr_h,
        input logic [7:0] addr_l,
        input logic [7:0] data_h,
        input logic [7:0] data_l
    );
        return op ^ addr_h ^ addr_l ^ data_h ^ data_l;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags expiry while it sits at TIMEOUT_CYCLES-1.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 85_000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, then increment up to the terminal value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_LAST)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == CNT_LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 7-byte command frames from the UART byte stream, verifies the
// XOR checksum and hands the command to the ODIN master via valid/ready.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 85_000,
    parameter int         CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_addr,
    output logic [15:0] cmd_data,
    output logic        csum_err,
    output logic        timeout_err,
    output logic [7:0]  err_count
);

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        csum_err_q, csum_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        tready_s;
    logic        cmd_valid_s;
    logic        accept_s;
    logic        in_frame_s;
    logic        expire_s;
    logic        timeout_s;
    logic [7:0]  csum_s;

    assign accept_s   = s_axis_tvalid && tready_s;
    assign in_frame_s = (state_q != ST_IDLE) && (state_q != ST_ISSUE);
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign timeout_s  = expire_s && !accept_s;
    assign csum_s     = frame_csum(op_q, addr_q[15:8], addr_q[7:0], data_q[15:8], data_q[7:0]);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (accept_s || !in_frame_s),
        .en_i     (in_frame_s),
        .expire_o (expire_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (s_axis_tdata == SYNC_BYTE)) state_d = ST_OP;
                else                                         state_d = ST_IDLE;
            end
            ST_OP: begin
                if (accept_s)       state_d = ST_ADDR_H;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_OP;
            end
            ST_ADDR_H: begin
                if (accept_s)       state_d = ST_ADDR_L;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_ADDR_H;
            end
            ST_ADDR_L: begin
                if (accept_s)       state_d = ST_DATA_H;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_ADDR_L;
            end
            ST_DATA_H: begin
                if (accept_s)       state_d = ST_DATA_L;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_DATA_H;
            end
            ST_DATA_L: begin
                if (accept_s)       state_d = ST_CSUM;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_DATA_L;
            end
            ST_CSUM: begin
                if (accept_s)       state_d = (s_axis_tdata == csum_s) ? ST_ISSUE : ST_IDLE;
                else if (timeout_s) state_d = ST_IDLE;
                else                state_d = ST_CSUM;
            end
            ST_ISSUE: begin
                if (cmd_ready) state_d = ST_IDLE;
                else           state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        tready_s    = 1'b1;
        cmd_valid_s = 1'b0;
        if (state_q == ST_ISSUE) begin
            tready_s    = 1'b0;
            cmd_valid_s = 1'b1;
        end else begin
            tready_s    = 1'b1;
            cmd_valid_s = 1'b0;
        end
    end

    // Field capture, error pulses and saturating error counter.
    always_comb begin
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        csum_err_d    = 1'b0;
        timeout_err_d = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_OP:     op_d       = s_axis_tdata;
                ST_ADDR_H: addr_d     = {s_axis_tdata, addr_q[7:0]};
                ST_ADDR_L: addr_d     = {addr_q[15:8], s_axis_tdata};
                ST_DATA_H: data_d     = {s_axis_tdata, data_q[7:0]};
                ST_DATA_L: data_d     = {data_q[15:8], s_axis_tdata};
                ST_CSUM:   csum_err_d = (s_axis_tdata != csum_s);
                default:   op_d       = op_q;
            endcase
        end else begin
            timeout_err_d = timeout_s;
        end
        err_count_d = err_count_q;
        if ((csum_err_d || timeout_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= 8'h00;
            addr_q        <= 16'h0000;
            data_q        <= 16'h0000;
            csum_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            op_q          <= op_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            csum_err_q    <= csum_err_d;
            timeout_err_q <= timeout_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign s_axis_tready = tready_s;
    assign cmd_valid     = cmd_valid_s;
    assign cmd_op        = op_q;
    assign cmd_addr      = addr_q;
    assign cmd_data      = data_q;
    assign csum_err      = csum_err_q;
    assign timeout_err   = timeout_err_q;
    assign err_count     = err_count_q;

endmodule
